id_ex_pipe_stage: RTL and testbench
===================================

Name: id_ex_pipe_stage

Overview:
Parametrised ID->EX pipeline stage register for the 5-stage CPU. It replaces the free-running ID/EX latch with a valid/ready handshake stage and a 2-entry skid buffer, so decode can stall without a combinational ready path from EX. It adds a flush input for branch squash and bubble insertion. It also provides a saturating stall counter for performance debug.

Parameters:
DATA_W, 64, width of reg_data1, reg_data2 and imm
WREG_W, 3, destination register index width
ADDR_W, 9, instruction address width
EXC_W, 5, EX control field width
MEMC_W, 1, MEM control field width
WBC_W, 2, WB control field width
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
flush  in  1  squash all held and incoming entries this cycle
id_valid  in  1  ID presents a valid bundle
id_ready  out  1  stage can accept; equals NOT skid_valid (registered state only)
ID_reg_data1, ID_reg_data2, ID_imm  in  DATA_W each  operand and immediate payload
ID_Wreg  in  WREG_W  destination register
ID_addr_ins  in  ADDR_W  instruction address
ID_EX_CTRL / ID_MEM_CTRL / ID_WB_CTRL  in  EXC_W / MEMC_W / WBC_W  control payload
ex_valid  out  1  main register holds a valid bundle
ex_ready  in  1  EX consumes the bundle this cycle
EX_reg_data1, EX_reg_data2, EX_imm, EX_Wreg, EX_addr_ins  out  widths as inputs  main-register payload
EX_EX_CTRL / EX_MEM_CTRL / EX_WB_CTRL  out  widths as inputs  control; forced to 0 when ex_valid=0
stall_cnt  out  CNT_W  saturating count of cycles with ex_valid=1 and ex_ready=0

Behaviour:
- Storage: main entry (drives EX_* outputs) and skid entry. Each entry is a full payload plus a valid bit.
- Accept: in_fire = id_valid & id_ready & ~flush. Drain: out_fire = ex_valid & ex_ready.
- Main loads when main is empty or out_fire:
  - from skid if skid_valid (skid then clears, or reloads with the new input if in_fire);
  - else from the input if in_fire;
  - else main becomes invalid.
- If main is valid, out_fire=0 and in_fire=1, the input goes to skid. id_ready drops the next cycle.
- Latency: 1 cycle from in_fire to ex_valid when empty. Full throughput when ex_ready stays 1. Order is strictly FIFO.
- id_ready is a function of the skid valid bit only. There is no combinational path from ex_ready or id_valid to id_ready.
- Bubble: when ex_valid=0, EX_EX_CTRL, EX_MEM_CTRL and EX_WB_CTRL output 0, so no register or memory write occurs downstream. Data outputs hold their last loaded value.
- Flush: next cycle both valid bits are 0. The same-cycle input is discarded. The same-cycle out_fire still counts as consumed by EX. Flush has priority over load.
- Stall counter: increments when ex_valid & ~ex_ready and saturates at 2^CNT_W-1. Flush does not clear it; only reset clears it.
- Reset (synchronous, dominates flush and handshakes):
  - all payload registers are 0, both valid bits are 0, stall_cnt is 0;
  - outputs after reset: ex_valid=0, id_ready=1, all EX_* outputs are 0.
  - Inputs are ignored while reset=1, including reset asserted mid-transfer.
- Skid full (both valid): id_ready=0. id_valid is ignored; ID must hold its payload.

Test Plan:
- Streaming: ex_ready=1; drive id_valid with ID_imm=1,2,3 on consecutive cycles -> EX_imm=1,2,3 one cycle later, ex_valid high 3 cycles, stall_cnt=0.
- Backpressure: ex_ready=0 after first accept; offer ID_imm=A,B,C -> main=A, skid=B, id_ready=0, C held. Release ex_ready -> outputs A, B, C in order, no loss or duplication. stall_cnt equals the stall cycles.
- Flush with skid full plus incoming valid -> next cycle ex_valid=0, id_ready=1, EX_WB_CTRL=0, EX_MEM_CTRL=0. The discarded input never appears on EX_*.
- Bubble: ID_WB_CTRL=2'b11 accepted, then id_valid=0 -> the following cycle shows ex_valid=0 and EX_WB_CTRL=0, while EX_reg_data1 retains its value.
- Reset mid-stall with both entries valid and stall_cnt=5 -> next cycle all outputs 0, id_ready=1, stall_cnt=0.
- Saturation with CNT_W=4: hold ex_ready=0 for 20 cycles with valid data -> stall_cnt stops at 15.

Source files
------------

// File: rtl/id_ex_pipe_stage.sv
// ID->EX pipeline stage with a valid/ready handshake, a 2-entry skid buffer
// (main + skid), flush/bubble support and a saturating EX stall counter.
module id_ex_pipe_stage #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned WREG_W = 3,
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned EXC_W  = 5,
    parameter int unsigned MEMC_W = 1,
    parameter int unsigned WBC_W  = 2,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,

    input  logic              id_valid,
    output logic              id_ready,
    input  logic [DATA_W-1:0] ID_reg_data1,
    input  logic [DATA_W-1:0] ID_reg_data2,
    input  logic [DATA_W-1:0] ID_imm,
    input  logic [WREG_W-1:0] ID_Wreg,
    input  logic [ADDR_W-1:0] ID_addr_ins,
    input  logic [EXC_W-1:0]  ID_EX_CTRL,
    input  logic [MEMC_W-1:0] ID_MEM_CTRL,
    input  logic [WBC_W-1:0]  ID_WB_CTRL,

    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [DATA_W-1:0] EX_reg_data1,
    output logic [DATA_W-1:0] EX_reg_data2,
    output logic [DATA_W-1:0] EX_imm,
    output logic [WREG_W-1:0] EX_Wreg,
    output logic [ADDR_W-1:0] EX_addr_ins,
    output logic [EXC_W-1:0]  EX_EX_CTRL,
    output logic [MEMC_W-1:0] EX_MEM_CTRL,
    output logic [WBC_W-1:0]  EX_WB_CTRL,

    output logic [CNT_W-1:0]  stall_cnt
);

    typedef struct packed {
        logic [DATA_W-1:0] data1;
        logic [DATA_W-1:0] data2;
        logic [DATA_W-1:0] imm;
        logic [WREG_W-1:0] wreg;
        logic [ADDR_W-1:0] addr;
        logic [EXC_W-1:0]  exc;
        logic [MEMC_W-1:0] memc;
        logic [WBC_W-1:0]  wbc;
    } payload_t;

    payload_t          in_pl;
    payload_t          main_q, main_d;
    payload_t          skid_q, skid_d;
    logic              main_vld_q, main_vld_d;
    logic              skid_vld_q, skid_vld_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic              in_fire;
    logic              out_fire;

    assign in_pl = '{
        data1: ID_reg_data1,
        data2: ID_reg_data2,
        imm:   ID_imm,
        wreg:  ID_Wreg,
        addr:  ID_addr_ins,
        exc:   ID_EX_CTRL,
        memc:  ID_MEM_CTRL,
        wbc:   ID_WB_CTRL
    };

    // Ready depends only on registered skid state, so EX never sees a
    // combinational path back into decode.
    assign id_ready = ~skid_vld_q;
    assign in_fire  = id_valid & id_ready & ~flush;
    assign out_fire = main_vld_q & ex_ready;

    always_comb begin
        main_d     = main_q;
        skid_d     = skid_q;
        main_vld_d = main_vld_q;
        skid_vld_d = skid_vld_q;

        if (flush) begin
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (!main_vld_q || out_fire) begin
            if (skid_vld_q) begin
                main_d     = skid_q;
                main_vld_d = 1'b1;
                if (in_fire) begin
                    skid_d     = in_pl;
                    skid_vld_d = 1'b1;
                end else begin
                    skid_vld_d = 1'b0;
                end
            end else if (in_fire) begin
                main_d     = in_pl;
                main_vld_d = 1'b1;
            end else begin
                main_vld_d = 1'b0;
            end
        end else if (in_fire) begin
            skid_d     = in_pl;
            skid_vld_d = 1'b1;
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (main_vld_q && !ex_ready && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            stall_q    <= '0;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
            stall_q    <= stall_d;
        end
    end

    assign ex_valid     = main_vld_q;
    assign EX_reg_data1 = main_q.data1;
    assign EX_reg_data2 = main_q.data2;
    assign EX_imm       = main_q.imm;
    assign EX_Wreg      = main_q.wreg;
    assign EX_addr_ins  = main_q.addr;
    // Control is masked on bubbles so nothing downstream writes state.
    assign EX_EX_CTRL   = main_vld_q ? main_q.exc  : '0;
    assign EX_MEM_CTRL  = main_vld_q ? main_q.memc : '0;
    assign EX_WB_CTRL   = main_vld_q ? main_q.wbc  : '0;
    assign stall_cnt    = stall_q;

endmodule

// File: tb/tb_id_ex_pipe_stage.sv
// Directed bench for id_ex_pipe_stage (CNT_W=4 so counter saturation is reachable).
module tb_id_ex_pipe_stage;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned WREG_W = 3;
    localparam int unsigned ADDR_W = 9;
    localparam int unsigned EXC_W  = 5;
    localparam int unsigned MEMC_W = 1;
    localparam int unsigned WBC_W  = 2;
    localparam int unsigned CNT_W  = 4;

    logic              clk = 1'b0;
    logic              reset, flush, id_valid, id_ready, ex_valid, ex_ready;
    logic [DATA_W-1:0] ID_reg_data1, ID_reg_data2, ID_imm;
    logic [WREG_W-1:0] ID_Wreg;
    logic [ADDR_W-1:0] ID_addr_ins;
    logic [EXC_W-1:0]  ID_EX_CTRL;
    logic [MEMC_W-1:0] ID_MEM_CTRL;
    logic [WBC_W-1:0]  ID_WB_CTRL;
    logic [DATA_W-1:0] EX_reg_data1, EX_reg_data2, EX_imm;
    logic [WREG_W-1:0] EX_Wreg;
    logic [ADDR_W-1:0] EX_addr_ins;
    logic [EXC_W-1:0]  EX_EX_CTRL;
    logic [MEMC_W-1:0] EX_MEM_CTRL;
    logic [WBC_W-1:0]  EX_WB_CTRL;
    logic [CNT_W-1:0]  stall_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    id_ex_pipe_stage #(
        .DATA_W(DATA_W), .WREG_W(WREG_W), .ADDR_W(ADDR_W), .EXC_W(EXC_W),
        .MEMC_W(MEMC_W), .WBC_W(WBC_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .id_valid(id_valid), .id_ready(id_ready),
        .ID_reg_data1(ID_reg_data1), .ID_reg_data2(ID_reg_data2), .ID_imm(ID_imm),
        .ID_Wreg(ID_Wreg), .ID_addr_ins(ID_addr_ins),
        .ID_EX_CTRL(ID_EX_CTRL), .ID_MEM_CTRL(ID_MEM_CTRL), .ID_WB_CTRL(ID_WB_CTRL),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .EX_reg_data1(EX_reg_data1), .EX_reg_data2(EX_reg_data2), .EX_imm(EX_imm),
        .EX_Wreg(EX_Wreg), .EX_addr_ins(EX_addr_ins),
        .EX_EX_CTRL(EX_EX_CTRL), .EX_MEM_CTRL(EX_MEM_CTRL), .EX_WB_CTRL(EX_WB_CTRL),
        .stall_cnt(stall_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every payload field is derived from one tag value so a bundle is
    // recognisable on any output.
    task automatic drive(input logic v, input logic [63:0] val);
        id_valid     = v;
        ID_imm       = val;
        ID_reg_data1 = val + 64'd100;
        ID_reg_data2 = val + 64'd200;
        ID_Wreg      = val[2:0];
        ID_addr_ins  = val[8:0];
        ID_EX_CTRL   = val[4:0];
        ID_MEM_CTRL  = val[0];
        ID_WB_CTRL   = val[1:0];
    endtask

    task automatic chk_bundle(input string tag, input logic [63:0] val);
        chk({tag, ".valid"}, 64'(ex_valid), 64'd1);
        chk({tag, ".imm"},   EX_imm, val);
        chk({tag, ".d1"},    EX_reg_data1, val + 64'd100);
        chk({tag, ".d2"},    EX_reg_data2, val + 64'd200);
        chk({tag, ".wreg"},  64'(EX_Wreg), 64'(val[2:0]));
        chk({tag, ".addr"},  64'(EX_addr_ins), 64'(val[8:0]));
        chk({tag, ".exc"},   64'(EX_EX_CTRL), 64'(val[4:0]));
        chk({tag, ".memc"},  64'(EX_MEM_CTRL), 64'(val[0]));
        chk({tag, ".wbc"},   64'(EX_WB_CTRL), 64'(val[1:0]));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; ex_ready = 1'b0;
        drive(1'b0, 64'd0);
        step(); step();
        reset = 1'b0;

        // Reset state
        chk("rst.ex_valid", 64'(ex_valid), 64'd0);
        chk("rst.id_ready", 64'(id_ready), 64'd1);
        chk("rst.imm", EX_imm, 64'd0);
        chk("rst.wbc", 64'(EX_WB_CTRL), 64'd0);
        chk("rst.stall", 64'(stall_cnt), 64'd0);

        // Streaming with EX always ready
        ex_ready = 1'b1;
        drive(1'b1, 64'd1); step(); chk_bundle("s1", 64'd1);
        drive(1'b1, 64'd2); step(); chk_bundle("s2", 64'd2);
        drive(1'b1, 64'd3); step(); chk_bundle("s3", 64'd3);
        chk("s3.id_ready", 64'(id_ready), 64'd1);
        // Bubble: control masked, data retained
        drive(1'b0, 64'd0); step();
        chk("bub.ex_valid", 64'(ex_valid), 64'd0);
        chk("bub.wbc", 64'(EX_WB_CTRL), 64'd0);
        chk("bub.exc", 64'(EX_EX_CTRL), 64'd0);
        chk("bub.d1", EX_reg_data1, 64'd103);
        chk("s.stall", 64'(stall_cnt), 64'd0);

        // Backpressure: A in main, B in skid, C held
        ex_ready = 1'b0;
        drive(1'b1, 64'hA); step();
        chk_bundle("bp.A", 64'hA);
        chk("bp.A.stall", 64'(stall_cnt), 64'd0);
        drive(1'b1, 64'hB); step();
        chk("bp.B.id_ready", 64'(id_ready), 64'd0);
        chk_bundle("bp.B.main", 64'hA);
        chk("bp.B.stall", 64'(stall_cnt), 64'd1);
        drive(1'b1, 64'hC); step();
        chk("bp.C.id_ready", 64'(id_ready), 64'd0);
        chk("bp.C.imm", EX_imm, 64'hA);
        step();
        chk("bp.stall3", 64'(stall_cnt), 64'd3);
        ex_ready = 1'b1; step();
        chk_bundle("bp.outB", 64'hB);
        chk("bp.outB.id_ready", 64'(id_ready), 64'd1);
        step();
        chk_bundle("bp.outC", 64'hC);
        drive(1'b0, 64'd0); step();
        chk("bp.empty", 64'(ex_valid), 64'd0);
        chk("bp.stall_end", 64'(stall_cnt), 64'd3);

        // Flush with skid full and an incoming valid
        ex_ready = 1'b0;
        drive(1'b1, 64'hD); step();
        drive(1'b1, 64'hE); step();
        chk("fl.full", 64'(id_ready), 64'd0);
        drive(1'b1, 64'hF); flush = 1'b1; step();
        flush = 1'b0; drive(1'b0, 64'd0);
        chk("fl.ex_valid", 64'(ex_valid), 64'd0);
        chk("fl.id_ready", 64'(id_ready), 64'd1);
        chk("fl.wbc", 64'(EX_WB_CTRL), 64'd0);
        chk("fl.memc", 64'(EX_MEM_CTRL), 64'd0);
        chk("fl.stall", 64'(stall_cnt), 64'd5);
        step();
        chk("fl.after.ex_valid", 64'(ex_valid), 64'd0);
        chk("fl.after.imm", EX_imm, 64'hD);
        ex_ready = 1'b1;
        drive(1'b1, 64'h11); step();
        chk_bundle("fl.next", 64'h11);

        // Reset mid-stall with both entries valid and stall_cnt=5
        drive(1'b0, 64'd0); reset = 1'b1; step(); reset = 1'b0;
        ex_ready = 1'b0;
        drive(1'b1, 64'h1D); step();
        drive(1'b1, 64'h1E); step();
        step(); step(); step(); step();
        chk("rm.stall5", 64'(stall_cnt), 64'd5);
        chk("rm.full", 64'(id_ready), 64'd0);
        reset = 1'b1; ex_ready = 1'b1; step();
        chk("rm.ex_valid", 64'(ex_valid), 64'd0);
        chk("rm.id_ready", 64'(id_ready), 64'd1);
        chk("rm.stall", 64'(stall_cnt), 64'd0);
        chk("rm.imm", EX_imm, 64'd0);
        chk("rm.d1", EX_reg_data1, 64'd0);
        chk("rm.d2", EX_reg_data2, 64'd0);
        chk("rm.addr", 64'(EX_addr_ins), 64'd0);
        step();
        chk("rm.hold.ex_valid", 64'(ex_valid), 64'd0);
        reset = 1'b0; drive(1'b0, 64'd0); step();
        chk("rm.idle", 64'(ex_valid), 64'd0);

        // Saturation (CNT_W=4)
        ex_ready = 1'b0;
        drive(1'b1, 64'h5A); step();
        drive(1'b0, 64'd0);
        chk("sat.0", 64'(stall_cnt), 64'd0);
        for (int i = 0; i < 14; i++) step();
        chk("sat.14", 64'(stall_cnt), 64'd14);
        step();
        chk("sat.15", 64'(stall_cnt), 64'd15);
        for (int i = 0; i < 5; i++) step();
        chk("sat.20", 64'(stall_cnt), 64'd15);
        chk_bundle("sat.hold", 64'h5A);
        ex_ready = 1'b1; step();
        chk("sat.drain", 64'(ex_valid), 64'd0);
        chk("sat.keep", 64'(stall_cnt), 64'd15);
        flush = 1'b1; step(); flush = 1'b0;
        chk("sat.flush_keep", 64'(stall_cnt), 64'd15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
